alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (32-bit operands, 4-bit ctrl, result + zero flag) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on both request and response sides, and registered ALU operands and result.
- Sits between the pipeline/multicycle units that issue ALU operations and the single ALU instance.

---
 rtl/alu_share_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Optional macro ALU_ILLEGAL_OP_EN adds a registered rsp_illegal_o flag.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_src1_i,
  input  logic [NUM_REQ*32-1:0] req_src2_i,
  input  logic [NUM_REQ*4-1:0]  req_ctrl_i,
  output logic [31:0]           alu_src1_o,
  output logic [31:0]           alu_src2_o,
  output logic [3:0]            alu_ctrl_o,
  input  logic [31:0]           alu_result_i,
  input  logic                  alu_zero_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [31:0]           rsp_result_o,
  output logic                  rsp_zero_o
`ifdef ALU_ILLEGAL_OP_EN
  ,
  output logic                  rsp_illegal_o
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] id_q;
  logic [31:0]     src1_q, src2_q;
  logic [3:0]      ctrl_q;

  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic [31:0]     grant_src1, grant_src2;
  logic [3:0]      grant_ctrl;
  int unsigned     cand;

  assign alu_src1_o = src1_q;
  assign alu_src2_o = src2_q;
  assign alu_ctrl_o = ctrl_q;

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_src1  = '0;
    grant_src2  = '0;
    grant_ctrl  = '0;
    cand        = '0;
    case (state_q)
      IDLE: begin
        // Offset i walks the requesters starting at the pointer; first hit wins.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          cand = i + int'(rr_ptr_q);
          if (cand >= NUM_REQ) cand = cand - NUM_REQ;
          for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_valid && j == cand && req_valid_i[j]) begin
              grant_valid    = 1'b1;
              grant_id       = ID_W'(j);
              grant_src1     = req_src1_i[32*j +: 32];
              grant_src2     = req_src2_i[32*j +: 32];
              grant_ctrl     = req_ctrl_i[4*j +: 4];
              req_ready_o[j] = 1'b1;
            end
          end
        end
        if (grant_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q      <= '0;
      id_q          <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      ctrl_q        <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_id_o      <= '0;
      rsp_result_o  <= '0;
      rsp_zero_o    <= 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
      rsp_illegal_o <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            src1_q <= grant_src1;
            src2_q <= grant_src2;
            ctrl_q <= grant_ctrl;
            id_q   <= grant_id;
          end
        end
        EXEC: begin
          rsp_result_o  <= alu_result_i;
          rsp_zero_o    <= alu_zero_i;
          rsp_id_o      <= id_q;
          rsp_valid_o   <= 1'b1;
`ifdef ALU_ILLEGAL_OP_EN
          rsp_illegal_o <= (ctrl_q == 4'b0101) || (ctrl_q == 4'b1111);
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rr_ptr_q    <= (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized + directed bench for alu_share_arbiter with a transaction-level model
// and a behavioural ALU standing in for the shared unit.
module tb_alu_share_arbiter;
  localparam int N    = 3;
  localparam int ID_W = 2;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*32-1:0] req_src1_i = '0;
  logic [N*32-1:0] req_src2_i = '0;
  logic [N*4-1:0]  req_ctrl_i = '0;
  logic [31:0]     alu_src1_o, alu_src2_o, alu_result_i;
  logic [3:0]      alu_ctrl_o;
  logic            alu_zero_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic [ID_W-1:0] rsp_id_o;
  logic [31:0]     rsp_result_o;
  logic            rsp_zero_o;
`ifdef ALU_ILLEGAL_OP_EN
  logic            rsp_illegal_o;
`endif

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_src1_i(req_src1_i), .req_src2_i(req_src2_i), .req_ctrl_i(req_ctrl_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o)
`ifdef ALU_ILLEGAL_OP_EN
    , .rsp_illegal_o(rsp_illegal_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return ~(a | b);
      4'b0110: return a - b;
      4'b0111: return {31'd0, $signed(a) < $signed(b)};
      4'b1000: return a << b[4:0];
      4'b1001: return a >> b[4:0];
      4'b1010: return $unsigned($signed(a) >>> b[4:0]);
      4'b1011: return {31'd0, a < b};
      4'b1100: return ~(a & b);
      4'b1101: return a ^ b;
      4'b1110: return a + b + 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_result_i = alu_fn(alu_src1_o, alu_src2_o, alu_ctrl_o);
    alu_zero_i   = (alu_result_i == 32'd0);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding op at most; last-served requester has lowest priority.
  typedef struct {
    int          id;
    logic [31:0] s1, s2, res;
    logic [3:0]  ctrl;
    logic        zero, ill;
  } txn_t;

  bit   busy = 0;
  int   age  = 0;
  int   last = N - 1;
  txn_t cur;
  int   grants[$];

  function automatic int pick_grant(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    req_src1_i[32*k +: 32] = a;
    req_src2_i[32*k +: 32] = b;
    req_ctrl_i[4*k +: 4]   = c;
  endtask

  // Called at a falling edge: drive, check, cross one rising edge, update model.
  task automatic step(input logic [N-1:0] v, input logic rr);
    int g;
    bit hs;
    logic [N-1:0] exp_ready;
    req_valid_i = v;
    rsp_ready_i = rr;
    #1;
    g = busy ? -1 : pick_grant(v);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready_o), 32'(exp_ready));
    hs = 0;
    if (busy && age >= 1) begin
      check("rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("rsp_id", 32'(rsp_id_o), 32'(cur.id));
      check("rsp_result", rsp_result_o, cur.res);
      check("rsp_zero", 32'(rsp_zero_o), 32'(cur.zero));
`ifdef ALU_ILLEGAL_OP_EN
      check("rsp_illegal", 32'(rsp_illegal_o), 32'(cur.ill));
`endif
      hs = rr;
    end else begin
      check("rsp_valid", 32'(rsp_valid_o), 32'd0);
    end
    if (busy) check("alu_src1", alu_src1_o, cur.s1);
    @(posedge clk_i);
    if (g >= 0) begin
      cur.id   = g;
      cur.s1   = req_src1_i[32*g +: 32];
      cur.s2   = req_src2_i[32*g +: 32];
      cur.ctrl = req_ctrl_i[4*g +: 4];
      cur.res  = alu_fn(cur.s1, cur.s2, cur.ctrl);
      cur.zero = (cur.res == 32'd0);
      cur.ill  = (cur.ctrl == 4'b0101) || (cur.ctrl == 4'b1111);
      busy = 1;
      age  = 0;
      grants.push_back(g);
    end else if (hs) begin
      busy = 0;
      last = cur.id;
    end else if (busy) begin
      age++;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    rst_i = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    busy = 0;
    last = N - 1;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_id", 32'(rsp_id_o), 32'd0);
    check("reset_result", rsp_result_o, 32'd0);
    check("reset_zero", 32'(rsp_zero_o), 32'd0);
    check("reset_ready", 32'(req_ready_o), 32'd0);
    check("reset_alu_src1", alu_src1_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single request: 5 + 3.
    set_req(0, 32'd5, 32'd3, 4'b0010);
    step(3'b001, 1'b1);
    step(3'b000, 1'b1);
    #1;
    check("single_valid", 32'(rsp_valid_o), 32'd1);
    check("single_result", rsp_result_o, 32'd8);
    check("single_zero", 32'(rsp_zero_o), 32'd0);
    check("single_id", 32'(rsp_id_o), 32'd0);
    step(3'b000, 1'b1);

    // Contention between req0 and req1 from pointer 0.
    do_reset();
    grants.delete();
    set_req(0, 32'd10, 32'd20, 4'b0010);
    set_req(1, 32'd30, 32'd30, 4'b0110);
    repeat (12) step(3'b011, 1'b1);
    check("cont_g0", 32'(grants[0]), 32'd0);
    check("cont_g1", 32'(grants[1]), 32'd1);
    check("cont_g2", 32'(grants[2]), 32'd0);
    check("cont_g3", 32'(grants[3]), 32'd1);

    // Backpressure with a zero result.
    do_reset();
    set_req(2, 32'd7, 32'd7, 4'b0110);
    step(3'b100, 1'b0);
    step(3'b000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_result", rsp_result_o, 32'd0);
      check("bp_zero", 32'(rsp_zero_o), 32'd1);
      step(3'b111, 1'b0);
    end
    step(3'b000, 1'b1);
    step(3'b001, 1'b1);
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);

    // Asynchronous reset while in EXEC.
    do_reset();
    set_req(0, 32'd1, 32'd2, 4'b0010);
    step(3'b001, 1'b1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    busy = 0;
    last = N - 1;
    set_req(1, 32'hDEAD0000, 32'h0000BEEF, 4'b0001);
    step(3'b010, 1'b1);
    step(3'b000, 1'b1);
    #1;
    check("after_rst_id", 32'(rsp_id_o), 32'd1);
    check("after_rst_result", rsp_result_o, 32'hDEADBEEF);
    step(3'b000, 1'b1);

    // Wrap-around with every requester valid.
    do_reset();
    grants.delete();
    repeat (12) step(3'b111, 1'b1);
    check("wrap_g0", 32'(grants[0]), 32'd0);
    check("wrap_g1", 32'(grants[1]), 32'd1);
    check("wrap_g2", 32'(grants[2]), 32'd2);
    check("wrap_g3", 32'(grants[3]), 32'd0);

`ifdef ALU_ILLEGAL_OP_EN
    do_reset();
    set_req(0, 32'd9, 32'd4, 4'b1111);
    step(3'b001, 1'b1);
    step(3'b000, 1'b1);
    #1;
    check("ill_flag", 32'(rsp_illegal_o), 32'd1);
    check("ill_result", rsp_result_o, 32'd0);
    step(3'b000, 1'b1);
    set_req(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1101);
    step(3'b010, 1'b1);
    step(3'b000, 1'b1);
    #1;
    check("legal_flag", 32'(rsp_illegal_o), 32'd0);
    check("legal_result", rsp_result_o, 32'd0);
    check("legal_zero", 32'(rsp_zero_o), 32'd1);
    step(3'b000, 1'b1);
`endif

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 800; c++) begin
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) begin
        logic [31:0] a;
        a = $urandom;
        set_req(k, a, ($urandom_range(0, 3) == 0) ? a : $urandom, 4'($urandom_range(0, 15)));
        v[k] = ($urandom_range(0, 2) != 0);
      end
      step(v, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
